tusca_uc: RTL and testbench

- Control unit (FSM) sequencing the TUSCA datapath.
- Loads thresholds over the config serial link, with retry on error.
- Runs the periodic measure → actuate → wait loop: triggers DHT11 measurement, pulses the servo, runs the inter-measurement delay counter.
- Pure sequencer; all data handling stays in the datapath.

---
 rtl/tusca_uc.sv | 117 +++++++++++
 tb/tb_tusca_uc.sv | 126 ++++++++++++
 2 files changed

// File: rtl/tusca_uc.sv
// tusca_uc: TUSCA control unit sequencing config load and the measure/actuate/wait loop.
// Optional measurement timeout with retry enabled by defining TUSCA_UC_TIMEOUT_EN.
module tusca_uc #(
    parameter int MAX_TENTATIVAS = 3,
    parameter int TIMEOUT_MEDIDA = 50_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ligar,
    input  logic       solicita_config,
    input  logic       pronto_medida,
    input  logic       pronto_config,
    input  logic       erro_config,
    input  logic       fim_delay,
    output logic       medir_dht11,
    output logic       receber_config,
    output logic       zera_delay,
    output logic       conta_delay,
    output logic       gira,
    output logic       erro,
    output logic       ativo,
    output logic [3:0] db_estado
);
    localparam int TW = $clog2(MAX_TENTATIVAS + 1);

    if (MAX_TENTATIVAS < 1 || TIMEOUT_MEDIDA < 2) begin : g_bad_params
        $error("tusca_uc: MAX_TENTATIVAS must be >= 1 and TIMEOUT_MEDIDA >= 2");
    end

    typedef enum logic [3:0] {
        INICIAL       = 4'h0,
        PREPARA       = 4'h1,
        CONFIG        = 4'h2,
        REPETE_CONFIG = 4'h3,
        MEDE          = 4'h4,
        ESPERA_MEDIDA = 4'h5,
        ATUALIZA      = 4'h6,
        ZERA_DELAY    = 4'h7,
        ESPERA_DELAY  = 4'h8,
        ERRO          = 4'hF
    } state_t;

    state_t state, next;
    logic [TW-1:0] tent, tent_next, tent_inc;
    logic tent_max;

    // saturating retry count; tent_max flags that this failure exhausts the retries
    assign tent_inc = (tent == TW'(MAX_TENTATIVAS)) ? tent : tent + 1'b1;
    assign tent_max = tent_inc == TW'(MAX_TENTATIVAS);

`ifdef TUSCA_UC_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_MEDIDA);
    logic [CW-1:0] tmo;
    logic expira;
    assign expira = tmo == CW'(TIMEOUT_MEDIDA - 1);
    always_ff @(posedge clock or negedge reset)
        if (!reset) tmo <= '0;
        else tmo <= (state == ESPERA_MEDIDA) ? tmo + 1'b1 : '0;
`endif

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            state <= INICIAL;
            tent  <= '0;
        end else begin
            state <= next;
            tent  <= tent_next;
        end

    always_comb begin
        next      = state;
        tent_next = tent;
        case (state)
            INICIAL:       if (ligar) next = PREPARA;
            PREPARA: begin
                next      = CONFIG;
                tent_next = '0;
            end
            CONFIG:
                if (pronto_config && !erro_config) begin
                    next      = MEDE;
                    tent_next = '0;
                end else if (pronto_config) begin
                    tent_next = tent_inc;
                    next      = tent_max ? ERRO : REPETE_CONFIG;
                end
            REPETE_CONFIG: next = CONFIG;
            MEDE:          next = ESPERA_MEDIDA;
            ESPERA_MEDIDA:
                if (pronto_medida) begin
                    next      = ATUALIZA;
                    tent_next = '0;
                end
`ifdef TUSCA_UC_TIMEOUT_EN
                else if (expira) begin
                    tent_next = tent_inc;
                    next      = tent_max ? ERRO : MEDE;
                end
`endif
            ATUALIZA:      next = ZERA_DELAY;
            ZERA_DELAY:    next = ESPERA_DELAY;
            ESPERA_DELAY:  next = fim_delay ? MEDE : solicita_config ? PREPARA : ESPERA_DELAY;
            ERRO:          next = ERRO;
            default:       next = INICIAL;
        endcase
        if (!ligar) next = INICIAL;
    end

    assign medir_dht11    = state == MEDE;
    assign receber_config = state == CONFIG;
    assign zera_delay     = state == PREPARA || state == ZERA_DELAY;
    assign conta_delay    = state == ESPERA_DELAY;
    assign gira           = state == ATUALIZA;
    assign erro           = state == ERRO;
    assign ativo          = state != INICIAL && state != ERRO;
    assign db_estado      = state;
endmodule

// File: tb/tb_tusca_uc.sv
// tb_tusca_uc: randomized scoreboard bench for tusca_uc against a spec-level reference model.
module tb_tusca_uc;
    localparam int MAX = 3;
    localparam int TMO = 10;

    logic clock = 1'b0, reset = 1'b0, ligar = 1'b0, solicita_config = 1'b0;
    logic pronto_medida = 1'b0, pronto_config = 1'b0, erro_config = 1'b0, fim_delay = 1'b0;
    logic medir_dht11, receber_config, zera_delay, conta_delay, gira, erro, ativo;
    logic [3:0] db_estado;
    logic [10:0] act;
    logic [10:0] sb[$];
    int tests = 0, fails = 0;
    int m_st = 0, m_tent = 0, m_tmo = 0;

    tusca_uc #(.MAX_TENTATIVAS(MAX), .TIMEOUT_MEDIDA(TMO)) dut (
        .clock(clock), .reset(reset), .ligar(ligar), .solicita_config(solicita_config),
        .pronto_medida(pronto_medida), .pronto_config(pronto_config), .erro_config(erro_config),
        .fim_delay(fim_delay), .medir_dht11(medir_dht11), .receber_config(receber_config),
        .zera_delay(zera_delay), .conta_delay(conta_delay), .gira(gira), .erro(erro),
        .ativo(ativo), .db_estado(db_estado)
    );

    always #5 clock = ~clock;
    assign act = {db_estado, medir_dht11, receber_config, zera_delay, conta_delay, gira, erro, ativo};

    // Output table per state: {state, medir, receber, zera, conta, gira, erro, ativo}
    function automatic logic [10:0] exp_out(input int s);
        return {4'(s), s == 4, s == 2, s == 1 || s == 7, s == 8, s == 6, s == 15, s != 0 && s != 15};
    endfunction

    task automatic check(input string name, input logic [10:0] got, input logic [10:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s at %0t: got st=%h out=%b, expected st=%h out=%b",
                     name, $time, got[10:7], got[6:0], want[10:7], want[6:0]);
        end
    endtask

    // Reference model: the state the unit occupies after the next edge, from the spec's transition rules
    task automatic model(input bit r, l, sol, pm, pc, ec, fd);
        int nx;
        if (!r) begin
            m_st = 0; m_tent = 0; m_tmo = 0;
            return;
        end
        nx = m_st;
        case (m_st)
            0: if (l) nx = 1;
            1: begin nx = 2; m_tent = 0; end
            2: if (pc && !ec) begin nx = 4; m_tent = 0; end
               else if (pc) begin
                   if (m_tent < MAX) m_tent++;
                   nx = (m_tent == MAX) ? 15 : 3;
               end
            3: nx = 2;
            4: begin nx = 5; m_tmo = 0; end
            5: if (pm) begin nx = 6; m_tent = 0; end
`ifdef TUSCA_UC_TIMEOUT_EN
               else if (m_tmo == TMO - 1) begin
                   if (m_tent < MAX) m_tent++;
                   nx = (m_tent == MAX) ? 15 : 4;
               end else m_tmo++;
`endif
            6: nx = 7;
            7: nx = 8;
            8: nx = fd ? 4 : sol ? 1 : 8;
            default: nx = m_st;
        endcase
        if (!l) nx = 0;
        m_st = nx;
    endtask

    // One cycle of stimulus: v = {reset, ligar, solicita, pronto_medida, pronto_config, erro_config, fim_delay}
    task automatic drive(input logic [6:0] v);
        @(negedge clock);
        {reset, ligar, solicita_config, pronto_medida, pronto_config, erro_config, fim_delay} = v;
        model(v[6], v[5], v[4], v[3], v[2], v[1], v[0]);
        sb.push_back(exp_out(m_st));
        if (!v[6]) begin
            #1 check("async_reset", act, 11'b0);
        end
    endtask

    initial begin : monitor
        logic [10:0] e;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("state_outputs", act, e);
            end
        end
    end

    localparam logic [6:0] R = 7'b0100000, I = 7'b1100000, OK = 7'b1100100, ER = 7'b1100110,
                           PM = 7'b1101000, SOL = 7'b1110000, OFF = 7'b1000000, FS = 7'b1110001;

    initial begin : stim
        logic [6:0] dir[$];
        dir = '{R, R, I, I, OK, I, PM, I, I, I, R, R, I, I, OK, I, PM, I, I, OK, SOL, I,
                ER, I, ER, I, ER, I, I, OFF, I, I, OK, I, FS, PM, I, I, FS, I, OFF,
                I, I, OFF, I, I, I, ER, I, ER, I, ER, I, OFF};
        foreach (dir[k]) drive(dir[k]);
`ifdef TUSCA_UC_TIMEOUT_EN
        drive(OFF); drive(I); drive(I); drive(OK);
        for (int k = 0; k < 40; k++) drive(I);
        drive(OFF); drive(I); drive(I); drive(OK); drive(I);
        for (int k = 0; k < 9; k++) drive(I);
        drive(PM); drive(I); drive(I); drive(OFF);
`endif
        for (int k = 0; k < 3000; k++)
            drive({$urandom_range(0, 199) != 0, $urandom_range(0, 29) != 0, $urandom_range(0, 5) == 0,
                   $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0,
                   $urandom_range(0, 4) == 0});
        repeat (3) @(posedge clock);
        #2;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
